week_5_not_pipe: RTL and testbench

//   Parametrised, pipelined bitwise inverter bank with a per-beat mode and valid/ready flow control.

---
 rtl/week_5_not_pipe.sv | 91 +++++++++
 tb/tb_week_5_not_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/week_5_not_pipe.sv
// Pipelined bitwise inverter bank: per-beat transform (pass/invert/mask/toggle)
// followed by PIPE_STAGES register stages under valid/ready flow control.
module week_5_not_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   inv_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] beat_count
);

  localparam int unsigned LAST = PIPE_STAGES - 1;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_INV    = 2'b01;
  localparam logic [1:0] MODE_MASK   = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  logic [PIPE_STAGES-1:0] stg_valid;
  logic [WIDTH-1:0]       stg_data [PIPE_STAGES];
  logic                   en;
  logic                   accept;
  logic                   deliver;
  logic                   phase;
  logic [WIDTH-1:0]       f_data;

  // The whole pipe advances together; a full pipe with a stalled sink holds everything.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign deliver  = out_valid & out_ready;

  assign out_valid = stg_valid[LAST];
  assign out_data  = stg_data[LAST];

  // Beat transform, using mode/mask presented alongside the beat.
  always_comb begin
    f_data = in_data;
    unique case (mode)
      MODE_PASS:   f_data = in_data;
      MODE_INV:    f_data = ~in_data;
      MODE_MASK:   f_data = in_data ^ inv_mask;
      MODE_TOGGLE: f_data = phase ? ~in_data : in_data;
      default:     f_data = in_data;
    endcase
  end

  // Toggle phase restarts at pass whenever a non-toggle beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else if (accept) begin
      phase <= (mode == MODE_TOGGLE) ? ~phase : 1'b0;
    end
  end

  // Stage shift register; empty slots still clock data so out_data never goes X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        stg_data[k] <= '0;
      end
    end else if (en) begin
      stg_valid[0] <= accept;
      stg_data[0]  <= f_data;
      for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
        stg_valid[k] <= stg_valid[k-1];
        stg_data[k]  <= stg_data[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if (deliver) begin
      beat_count <= beat_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_week_5_not_pipe.sv
// Directed bench for week_5_not_pipe: default build, a 4-bit counter build and a
// single-stage build.
module tb_week_5_not_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  mode;
  logic [7:0]  inv_mask;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [15:0] beat_count;

  logic        c4_in_ready, c4_out_valid;
  logic [7:0]  c4_out_data;
  logic [3:0]  c4_beat_count;

  logic        p1_in_valid, p1_out_ready;
  logic        p1_in_ready, p1_out_valid;
  logic [7:0]  p1_out_data;
  logic [15:0] p1_beat_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] eq[$];

  always #5 clk = ~clk;

  week_5_not_pipe #(.WIDTH(8), .PIPE_STAGES(2), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .inv_mask(inv_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .beat_count(beat_count));

  week_5_not_pipe #(.WIDTH(8), .PIPE_STAGES(2), .COUNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c4_in_ready),
    .in_data(in_data), .mode(mode), .inv_mask(inv_mask), .out_valid(c4_out_valid),
    .out_ready(out_ready), .out_data(c4_out_data), .beat_count(c4_beat_count));

  week_5_not_pipe #(.WIDTH(8), .PIPE_STAGES(1), .COUNT_W(16)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
    .in_data(in_data), .mode(mode), .inv_mask(inv_mask), .out_valid(p1_out_valid),
    .out_ready(p1_out_ready), .out_data(p1_out_data), .beat_count(p1_beat_count));

  // Record every delivered beat of the default build.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag);
    chk({tag, "_len"}, 32'(q.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      if (i < q.size()) chk($sformatf("%s_%0d", tag, i), 32'(q[i]), 32'(eq[i]));
    end
    q.delete();
    eq.delete();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k);
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    inv_mask = k;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; inv_mask = '0;
    out_ready = 1'b0; p1_in_valid = 1'b0; p1_out_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    cyc();

    // Test 1: invert all, two-cycle latency
    out_ready = 1'b1;
    beat(2'b01, 8'hA5, 8'h00);
    chk("t1_valid_lat1", 32'(out_valid), 32'd0);
    cyc();
    chk("t1_valid_lat2", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h5A);
    cyc();
    chk("t1_count", 32'(beat_count), 32'd1);
    chk("t1_valid_after", 32'(out_valid), 32'd0);
    eq = '{8'h5A};
    chk_q("t1_q");

    // Test 2: masked invert and pass
    beat(2'b10, 8'h33, 8'h0F);
    beat(2'b00, 8'h33, 8'h0F);
    repeat (3) cyc();
    eq = '{8'h3C, 8'h33};
    chk_q("t2_q");
    chk("t2_count", 32'(beat_count), 32'd3);

    // Test 3: toggle run, then pass clears the phase
    repeat (4) beat(2'b11, 8'hFF, 8'h00);
    beat(2'b00, 8'h12, 8'h00);
    beat(2'b11, 8'hFF, 8'h00);
    repeat (3) cyc();
    eq = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h12, 8'hFF};
    chk_q("t3_q");
    chk("t3_count", 32'(beat_count), 32'd9);

    // Test 4: 8-beat stream with the sink stalled on cycles 3-5
    begin
      int sent = 0;
      for (int c = 1; c <= 16; c++) begin
        out_ready = !(c >= 3 && c <= 5);
        in_valid  = (sent < 8);
        mode      = 2'b00;
        in_data   = 8'h10 + 8'(sent);
        #1;
        if (c <= 10) chk($sformatf("t4_in_ready_c%0d", c), 32'(in_ready),
                         (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
        if (in_valid && in_ready) sent++;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    eq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    chk_q("t4_q");
    chk("t4_count", 32'(beat_count), 32'd17);
    // 17 deliveries on a 4-bit counter wraps to 1
    chk("t6_c4_wrap", 32'(c4_beat_count), 32'd1);

    // Test 5: asynchronous reset with two beats in flight
    beat(2'b01, 8'h01, 8'h00);
    beat(2'b01, 8'h02, 8'h00);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_count", 32'(beat_count), 32'd0);
    q.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("t5_post_valid", 32'(out_valid), 32'd0);
    eq.delete();
    chk_q("t5_q");

    // Test 6b: single-stage build has one-cycle latency
    p1_out_ready = 1'b1;
    p1_in_valid  = 1'b1;
    mode = 2'b01; in_data = 8'hA5;
    cyc();
    p1_in_valid = 1'b0;
    chk("t6_p1_valid", 32'(p1_out_valid), 32'd1);
    chk("t6_p1_data", 32'(p1_out_data), 32'h5A);
    cyc();
    chk("t6_p1_count", 32'(p1_beat_count), 32'd1);
    chk("t6_p1_valid_after", 32'(p1_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
